sccb_init_sequencer: RTL and testbench



---
 rtl/sccb_init_sequencer.sv | 142 ++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_sequencer.sv
// Walks a {reg_addr, reg_data} ROM and issues one SCCB write per entry.
// Supports power-up and embedded delays, NACK retries, and a done/error report.
module sccb_init_sequencer #(
  parameter logic [6:0] DEV_ADDR  = 7'h21,
  parameter int         ROM_AW    = 8,
  parameter int         PWR_DELAY = 1000,
  parameter int         CMD_DELAY = 10000,
  parameter int         MAX_RETRY = 3,
  parameter int         CNT_W     = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_req,
  output logic [6:0]        o_dev_addr,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_reg_data,
  input  logic              i_ready,
  input  logic              i_done,
  input  logic              i_nack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ROM_AW:0]   o_count
);
  localparam logic [15:0]       END_MARK = 16'hFFFF;
  localparam logic [15:0]       DLY_MARK = 16'hFFF0;
  localparam logic [ROM_AW-1:0] IDX_LAST = '1;
  localparam int                RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]     RTY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_DELAY, S_FETCH, S_DECODE,
    S_ISSUE, S_WAIT_DONE, S_DONE, S_ERROR
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ROM_AW-1:0] r_idx;
  logic [RW-1:0]     r_retry;
  logic              r_last;   // delay marker sat in the final ROM slot

  assign o_dev_addr = DEV_ADDR;
  assign o_rom_addr = r_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_last     <= 1'b0;
      o_req      <= 1'b0;
      o_reg_addr <= '0;
      o_reg_data <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_idx   <= '0;
            r_retry <= '0;
            r_last  <= 1'b0;
            o_count <= '0;
            o_done  <= 1'b0;
            o_error <= 1'b0;
            o_busy  <= 1'b1;
            r_cnt   <= CNT_W'(PWR_DELAY);
            r_state <= S_PWR_WAIT;
          end
        end
        S_PWR_WAIT, S_DELAY: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_last) begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_FETCH;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (i_rom_data == END_MARK) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (i_rom_data == DLY_MARK) begin
            r_cnt   <= CNT_W'(CMD_DELAY);
            r_state <= S_DELAY;
            if (r_idx == IDX_LAST) r_last <= 1'b1;
            else                   r_idx  <= r_idx + ROM_AW'(1);
          end else begin
            o_reg_addr <= i_rom_data[15:8];
            o_reg_data <= i_rom_data[7:0];
            o_req      <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (o_req && i_ready) begin
            o_req   <= 1'b0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (i_done) begin
            if (!i_nack) begin
              o_count <= o_count + (ROM_AW+1)'(1);
              r_retry <= '0;
              if (r_idx == IDX_LAST) begin
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + ROM_AW'(1);
                r_state <= S_FETCH;
              end
            end else if (r_retry < RTY_MAX) begin
              r_retry <= r_retry + RW'(1);
              o_req   <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              o_error <= 1'b1;
              o_busy  <= 1'b0;
              r_state <= S_ERROR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench: ROM model, I2C engine model with programmable NACKs, timing monitor.
module tb_sccb_init_sequencer;
  localparam int ROM_AW = 2, PWR = 10, CMD = 50, ACK_LAT = 20;

  logic              clk = 0, rst = 1, i_start = 0;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_q = '0;
  logic              req, ready_en = 1, i_ready, i_done, i_nack;
  logic [6:0]        dev_addr;
  logic [7:0]        reg_addr, reg_data;
  logic              busy, done, err;
  logic [ROM_AW:0]   count;

  logic [15:0] rom [4];
  int  cyc = 0, n_chk = 0, n_err = 0;
  int  n_acc, nack_issued, nack_first = 0;
  bit  nack_all = 0, eng_busy, prev_req;
  int  eng_cnt, t_start;
  logic [7:0] ra_q[$], rd_q[$];
  int  rise_q[$], done_q[$];

  sccb_init_sequencer #(.DEV_ADDR(7'h21), .ROM_AW(ROM_AW), .PWR_DELAY(PWR),
                        .CMD_DELAY(CMD), .MAX_RETRY(3), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .o_rom_addr(rom_addr),
    .i_rom_data(rom_q), .o_req(req), .o_dev_addr(dev_addr), .o_reg_addr(reg_addr),
    .o_reg_data(reg_data), .i_ready(i_ready), .i_done(i_done), .i_nack(i_nack),
    .o_busy(busy), .o_done(done), .o_error(err), .o_count(count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[rom_addr];
  assign i_ready = ready_en && !eng_busy;

  // Engine: accepts on req&ready, answers ACK_LAT cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy <= 0; eng_cnt <= 0; i_done <= 0; i_nack <= 0;
      n_acc <= 0; nack_issued <= 0; ra_q.delete(); rd_q.delete();
    end else begin
      i_done <= 0; i_nack <= 0;
      if (eng_busy) begin
        if (eng_cnt == 1) begin
          eng_busy <= 0; i_done <= 1;
          i_nack <= nack_all || (nack_issued < nack_first);
          nack_issued <= nack_issued + 1;
        end else eng_cnt <= eng_cnt - 1;
      end else if (req && i_ready) begin
        eng_busy <= 1; eng_cnt <= ACK_LAT; n_acc <= n_acc + 1;
        ra_q.push_back(reg_addr); rd_q.push_back(reg_data);
      end
    end
  end

  // cyc value k at a negedge names the posedge that produced the level
  always @(negedge clk) begin
    if (rst) begin rise_q.delete(); done_q.delete(); prev_req <= 0; end
    else begin
      if (req && !prev_req) rise_q.push_back(cyc);
      if (i_done) done_q.push_back(cyc);
      prev_req <= req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic start_seq();
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0; t_start = cyc;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < 5000) begin @(negedge clk); n++; end
    chk(tag, {31'b0, done | err}, 32'd1);
  endtask

  task automatic load_rom(input logic [15:0] a, b, c, d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  initial begin
    int rb, db, ab, n;
    load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, err}, 0);
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_romaddr", {30'b0, rom_addr}, 0);
    chk("dev_addr", {25'b0, dev_addr}, 32'h21);
    rst = 0;

    // Basic two-write sequence
    start_seq();
    wait_end("s1_end");
    chk("s1_nacc", n_acc, 2);
    chk("s1_ra0", {24'b0, ra_q[0]}, 32'h12); chk("s1_rd0", {24'b0, rd_q[0]}, 32'h80);
    chk("s1_ra1", {24'b0, ra_q[1]}, 32'h12); chk("s1_rd1", {24'b0, rd_q[1]}, 32'h04);
    chk("s1_count", {29'b0, count}, 2);
    chk("s1_done", {31'b0, done}, 1);
    chk("s1_busy", {31'b0, busy}, 0);
    chk("s1_first_req", rise_q[0] - t_start, PWR + 2);

    // Restart straight from DONE with an embedded delay marker
    load_rom(16'h3A04, 16'hFFF0, 16'h1100, 16'hFFFF);
    rb = rise_q.size(); db = done_q.size(); ab = n_acc;
    start_seq();
    chk("s2_done_cleared", {31'b0, done}, 0);
    chk("s2_busy", {31'b0, busy}, 1);
    wait_end("s2_end");
    chk("s2_count", {29'b0, count}, 2);
    chk("s2_nacc", n_acc - ab, 2);
    chk("s2_ra1", {24'b0, ra_q[ab+1]}, 32'h11);
    // 3 edges from i_done to decoding the marker, then CMD+2 from counter load to o_req
    chk("s2_gap", rise_q[rb+1] - done_q[db], CMD + 5);

    // Two NACKs then ACK on entry 0
    do_reset();
    load_rom(16'h3A04, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    nack_first = 2;
    start_seq();
    wait_end("s3_end");
    chk("s3_nacc", n_acc, 3);
    for (int i = 0; i < 3; i++) begin
      chk("s3_ra", {24'b0, ra_q[i]}, 32'h3A);
      chk("s3_rd", {24'b0, rd_q[i]}, 32'h04);
    end
    chk("s3_count", {29'b0, count}, 1);
    chk("s3_error", {31'b0, err}, 0);
    chk("s3_done", {31'b0, done}, 1);

    // NACK forever: retries exhausted
    do_reset();
    nack_first = 0; nack_all = 1;
    start_seq();
    wait_end("s4_end");
    chk("s4_nacc", n_acc, 4);
    chk("s4_error", {31'b0, err}, 1);
    chk("s4_done", {31'b0, done}, 0);
    chk("s4_romaddr", {30'b0, rom_addr}, 0);
    chk("s4_count", {29'b0, count}, 0);
    chk("s4_busy", {31'b0, busy}, 0);
    nack_all = 0;

    // Engine stalls with ready low; a stray start while busy must be ignored
    do_reset();
    load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    ready_en = 0;
    start_seq();
    n = 0;
    while (!req && n < 100) begin @(negedge clk); n++; end
    chk("s5_req_seen", {31'b0, req}, 1);
    for (int i = 0; i < 30; i++) begin
      i_start = (i == 10);
      @(negedge clk);
      chk("s5_req_hold", {31'b0, req}, 1);
      chk("s5_field_hold", {16'b0, reg_addr, reg_data}, 32'h1280);
    end
    i_start = 0;
    chk("s5_no_accept", n_acc, 0);
    ready_en = 1;
    wait_end("s5_end");
    chk("s5_nacc", n_acc, 2);
    chk("s5_count", {29'b0, count}, 2);
    chk("s5_ra0", {24'b0, ra_q[0]}, 32'h12);

    // Reset while the second write is outstanding
    do_reset();
    start_seq();
    n = 0;
    while (n_acc < 2 && n < 500) begin @(negedge clk); n++; end
    chk("s6_second_acc", n_acc, 2);
    repeat (3) @(negedge clk);
    chk("s6_count_pre", {29'b0, count}, 1);
    rst = 1; #1;
    chk("s6_req_rst", {31'b0, req}, 0);
    chk("s6_busy_rst", {31'b0, busy}, 0);
    chk("s6_count_rst", {29'b0, count}, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    start_seq();
    wait_end("s6_end");
    chk("s6_first_req", rise_q[0] - t_start, PWR + 2);
    chk("s6_ra0", {24'b0, ra_q[0]}, 32'h12);
    chk("s6_rd0", {24'b0, rd_q[0]}, 32'h80);
    chk("s6_count", {29'b0, count}, 2);

    // Four writes fill the ROM: finish on the last slot, no wrap
    do_reset();
    load_rom(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    start_seq();
    wait_end("s7_end");
    chk("s7_count", {29'b0, count}, 4);
    chk("s7_nacc", n_acc, 4);
    chk("s7_done", {31'b0, done}, 1);
    chk("s7_romaddr", {30'b0, rom_addr}, 3);
    repeat (50) @(negedge clk);
    chk("s7_no_extra", n_acc, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
